// File: rtl/line_buffer_pkg.sv
// line_buffer_pkg: default geometry and read-pointer step helper for line_buffer
//   LB_M / LB_W / LB_N / LB_S : default rows, bytes per row, window width, stride
//   next_rd()                 : next window column after one read request
package line_buffer_pkg;

    localparam int LB_M = 3;
    localparam int LB_W = 512;
    localparam int LB_N = 4;
    localparam int LB_S = 2;

    // Restart at column 0 whenever a further step would push the window
    // past the last column of the row.
    function automatic int next_rd(input int rd, input int step, input int w, input int n);
        return (rd + step > w - n) ? 0 : rd + step;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: M-row byte line store presenting an M x n sliding window
//   i_clk                   : clock, all state on rising edge
//   i_rst                   : synchronous active-high reset, clears pointers and storage
//   i_data, i_data_valid    : write stream, stored sequentially row by row
//   output_needs_to_be_read : advances the window by m columns
//   o_data                  : window, row 0 in the top n bytes, column rdPntr most significant
module line_buffer
    import line_buffer_pkg::*;
#(
    parameter  int M          = LB_M,
    parameter  int W          = LB_W,
    parameter  int n          = LB_N,
    parameter  int m          = LB_S,
    localparam int DATA_WIDTH = M * n * 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_data,
    input  logic                  i_data_valid,
    input  logic                  output_needs_to_be_read,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int WP_W = (M * W > 1) ? $clog2(M * W) : 1;
    localparam int RP_W = (W > 1) ? $clog2(W) : 1;

    logic [7:0]      line [M*W];
    logic [WP_W-1:0] wrPntr;
    logic [RP_W-1:0] rdPntr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            line   <= '{default: '0};
            wrPntr <= '0;
            rdPntr <= '0;
        end else begin
            if (i_data_valid) begin
                line[wrPntr] <= i_data;
                wrPntr       <= (wrPntr == WP_W'(M * W - 1)) ? '0 : wrPntr + 1'b1;
            end
            if (output_needs_to_be_read)
                rdPntr <= RP_W'(next_rd(int'(rdPntr), m, W, n));
        end
    end

    // rdPntr never exceeds W-n, so every tap stays inside its own row.
    for (genvar r = 0; r < M; r++) begin : g_row
        for (genvar j = 0; j < n; j++) begin : g_col
            assign o_data[(M-1-r)*n*8 + (n-1-j)*8 +: 8] = line[WP_W'(r * W + j) + WP_W'(rdPntr)];
        end
    end

endmodule

// File: tb/tb_line_buffer.sv
// tb_line_buffer: directed self-checking bench for line_buffer
module tb_line_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        data_valid;
    logic        rd_req;
    logic [95:0] o_data;
    int          checks = 0;
    int          fails  = 0;

    line_buffer dut (
        .i_clk                   (clk),
        .i_rst                   (rst),
        .i_data                  (data),
        .i_data_valid            (data_valid),
        .output_needs_to_be_read (rd_req),
        .o_data                  (o_data)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; returns #1 after the edge with inputs idle.
    task automatic cycle(input logic r, input logic v, input logic [7:0] d, input logic q);
        rst = r; data_valid = v; data = d; rd_req = q;
        @(posedge clk);
        #1;
        rst = 1'b0; data_valid = 1'b0; data = 8'h00; rd_req = 1'b0;
    endtask

    // Window of a fully filled buffer where every row holds column mod 256.
    function automatic logic [95:0] fill_win(input int p);
        logic [31:0] rw;
        for (int j = 0; j < 4; j++) rw[(3-j)*8 +: 8] = 8'((p + j) % 256);
        return {rw, rw, rw};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        checks++; if (dut.wrPntr !== 11'd0) begin fails++; $display("FAIL reset_wr got %0d want 0", dut.wrPntr); end
        checks++; if (dut.rdPntr !== 9'd0) begin fails++; $display("FAIL reset_rd got %0d want 0", dut.rdPntr); end
        checks++; if (o_data !== 96'h0) begin fails++; $display("FAIL reset_out got %h want 0", o_data); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 1536; i++) cycle(1'b0, 1'b1, 8'(i % 256), 1'b0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (dut.line[r*512 + c] !== 8'(c)) begin
                    fails++; $display("FAIL fill_line[%0d] got %h want %h", r*512 + c, dut.line[r*512 + c], 8'(c));
                end
            end
        checks++; if (dut.line[1535] !== 8'hFF) begin fails++; $display("FAIL fill_last got %h want ff", dut.line[1535]); end
        checks++; if (dut.wrPntr !== 11'd0) begin fails++; $display("FAIL fill_wrap got %0d want 0", dut.wrPntr); end
        checks++; if (o_data !== 96'h00010203_00010203_00010203) begin fails++; $display("FAIL fill_win got %h", o_data); end
    endtask

    task automatic test_slide();
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (dut.rdPntr !== 9'd2) begin fails++; $display("FAIL slide_rd2 got %0d want 2", dut.rdPntr); end
        checks++; if (o_data !== 96'h02030405_02030405_02030405) begin fails++; $display("FAIL slide_win2 got %h", o_data); end
        for (int p = 4; p <= 8; p += 2) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            checks++; if (dut.rdPntr !== 9'(p)) begin fails++; $display("FAIL slide_rd got %0d want %0d", dut.rdPntr, p); end
            checks++; if (o_data !== fill_win(p)) begin fails++; $display("FAIL slide_win%0d got %h want %h", p, o_data, fill_win(p)); end
        end
    endtask

    task automatic test_read_wrap();
        for (int i = 0; i < 250; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (dut.rdPntr !== 9'd508) begin fails++; $display("FAIL wrap_pre got %0d want 508", dut.rdPntr); end
        checks++; if (o_data !== 96'hFCFDFEFF_FCFDFEFF_FCFDFEFF) begin fails++; $display("FAIL wrap_lastwin got %h", o_data); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (dut.rdPntr !== 9'd0) begin fails++; $display("FAIL wrap_rd got %0d want 0", dut.rdPntr); end
        checks++; if (o_data !== 96'h00010203_00010203_00010203) begin fails++; $display("FAIL wrap_win got %h", o_data); end
    endtask

    task automatic test_simultaneous();
        cycle(1'b0, 1'b1, 8'hAA, 1'b0);
        cycle(1'b0, 1'b1, 8'hBB, 1'b0);
        checks++; if (o_data !== 96'hAABB0203_00010203_00010203) begin fails++; $display("FAIL sim_pre got %h", o_data); end
        cycle(1'b0, 1'b1, 8'hCC, 1'b1);
        checks++; if (dut.rdPntr !== 9'd2) begin fails++; $display("FAIL sim_rd got %0d want 2", dut.rdPntr); end
        checks++; if (dut.wrPntr !== 11'd3) begin fails++; $display("FAIL sim_wr got %0d want 3", dut.wrPntr); end
        checks++; if (o_data !== 96'hCC030405_02030405_02030405) begin fails++; $display("FAIL sim_win got %h", o_data); end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 8'(i + 1), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        checks++; if (o_data !== 96'h0708090A_00000000_00000000) begin fails++; $display("FAIL mid_win got %h", o_data); end
        cycle(1'b1, 1'b1, 8'h77, 1'b1);
        checks++; if (dut.wrPntr !== 11'd0) begin fails++; $display("FAIL mid_wr got %0d want 0", dut.wrPntr); end
        checks++; if (dut.rdPntr !== 9'd0) begin fails++; $display("FAIL mid_rd got %0d want 0", dut.rdPntr); end
        checks++; if (o_data !== 96'h0) begin fails++; $display("FAIL mid_out got %h want 0", o_data); end
        checks++; if (dut.line[99] !== 8'h00) begin fails++; $display("FAIL mid_clear got %h want 00", dut.line[99]); end
        cycle(1'b0, 1'b1, 8'h5A, 1'b0);
        checks++; if (dut.line[0] !== 8'h5A) begin fails++; $display("FAIL mid_first got %h want 5a", dut.line[0]); end
        checks++; if (dut.wrPntr !== 11'd1) begin fails++; $display("FAIL mid_wr1 got %0d want 1", dut.wrPntr); end
        checks++; if (o_data !== 96'h5A000000_00000000_00000000) begin fails++; $display("FAIL mid_win2 got %h", o_data); end
    endtask

    initial begin
        rst = 1'b0; data = 8'h00; data_valid = 1'b0; rd_req = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_slide();
        test_read_wrap();
        test_simultaneous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/line_buffer.md
# line_buffer

Byte-wide multi-row line buffer that sits between the pixel stream source and the convolution window engine. Stores M rows of W bytes, filled sequentially by a write stream, and presents an M×n byte window (n consecutive columns from every row) as one flat output word. Each read request slides the window right by stride m.

## Interface

Parameters:
- M, 3, number of rows (lines) stored
- W, 512, bytes per row
- n, 4, window width in columns
- m, 2, horizontal stride applied per read request
- DATA_WIDTH (derived, not overridable), M*n*8, output word width

Ports:
- i_clk  input  1  single clock, all state updates on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_data  input  8  write byte
- i_data_valid  input  1  write strobe; i_data stored this edge when high
- output_needs_to_be_read  input  1  read request; advances window by m this edge when high
- o_data  output  M*n*8  current window contents

## Operation

- Storage: flat byte array `line[0 .. M*W-1]`; row r, column c at index r*W + c. Internal pointer names `wrPntr` and `rdPntr`, visible to benches by hierarchical reference, together with `line`.
- Write: on an edge with i_data_valid=1, `line[wrPntr] <= i_data`; `wrPntr` increments by 1; wraps from M*W-1 to 0. Fills row 0 first, then row 1, and so on.
- Read: on an edge with output_needs_to_be_read=1, `rdPntr` advances by m. If `rdPntr + m > W - n`, it wraps to 0 instead, so the window never indexes past column W-1.
- Output packing is combinational from `line` and `rdPntr`:
  - the byte `line[r*W + rdPntr + j]` occupies bits `[(M-1-r)*n*8 + (n-1-j)*8 +: 8]`;
  - row 0 is in the most-significant n bytes;
  - within a row, column rdPntr is the most significant byte.
- Write and read are independent. Both may occur on the same edge, and both take effect on that edge.
- No full/empty tracking; the producer and consumer schedule fills and reads. A write into a byte currently in the window changes o_data after that edge.
- Reset: `wrPntr`=0, `rdPntr`=0, all `line` bytes cleared to 0, so o_data=0. Reset has priority over a write or read on the same edge. Reset mid-fill discards prior contents and restarts at index 0.

## Timing

- Write latency: data presented with i_data_valid on edge k is readable in o_data after edge k.
- Read: a request sampled high on edge k gives the window at the new `rdPntr` after edge k. No extra register stage.
- Each cycle the request is high advances the window once; holding it high N cycles advances it N*m columns.
- o_data is valid continuously, with no valid strobe.

## Structure

- Single module, no package required. Parameters are local to the block.
- No sub-module needed. The window mux may be a generate loop over r and j.
- Array is plain registers (reset clear required); do not infer BRAM.

## Test plan

- Reset: hold i_rst 3 cycles -> `wrPntr`=0, `rdPntr`=0, o_data=0.
- Full fill: write M*W=1536 bytes, value = index mod 256, on consecutive cycles -> `line[0..3]`=00 01 02 03, `line[512..515]`=00 01 02 03, `line[1024..1027]`=00 01 02 03; `wrPntr` wraps to 0.
- Slide:
  - after the fill, pulse read once -> `rdPntr`=2, o_data = bytes 02 03 04 05 per row, i.e. 0x02030405_02030405_02030405;
  - repeat for `rdPntr`=4, 6 and 8; each window is checked against the packing formula.
- Read wrap: issue reads until `rdPntr`=508, then one more read -> `rdPntr`=0; the window shows columns 0..3.
- Simultaneous events: a write to `line[rdPntr]` and a read on the same edge -> both applied; o_data reflects the new pointer and the new byte.
- Reset mid-operation: assert i_rst after 100 writes and several reads -> pointers are 0 and o_data is 0 on the next edge; the next write lands at index 0.
